// File: rtl/mont_reduce.sv
// rtl/mont_reduce.sv - three-stage Montgomery reduction (r = T * 2^-16 mod q) for Kyber products
// All stages advance together on a single global enable; bubbles are kept in place.
module mont_reduce #(
  parameter int Q        = 3329,
  parameter int R_BITS   = 16,
  parameter int QINV_NEG = 3327
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_r,
  output logic        busy
);

  localparam int T_W = 24;
  localparam int U_W = 29;
  localparam int S_W = U_W - R_BITS;

  localparam logic [R_BITS-1:0] QINV_L = R_BITS'(QINV_NEG);
  localparam logic [S_W-1:0]    Q_S    = S_W'(Q);
  localparam logic [U_W-1:0]    Q_U    = U_W'(Q);

  logic              adv;
  logic              s1_valid;
  logic [T_W-1:0]    s1_t;
  logic [R_BITS-1:0] s1_m;
  logic              s2_valid;
  logic [S_W-1:0]    s2_t;

  logic [R_BITS-1:0] m_next;
  logic [U_W-1:0]    u;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = s1_valid | s2_valid | out_valid;

  // Multiply truncates to R_BITS, which is exactly the mod 2^R reduction of m.
  assign m_next = in_t[R_BITS-1:0] * QINV_L;
  assign u      = U_W'(s1_t) + U_W'(s1_m) * Q_U;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_t      <= '0;
      s1_m      <= '0;
      s2_valid  <= 1'b0;
      s2_t      <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_t      <= in_t;
      s1_m      <= m_next;
      s2_valid  <= s1_valid;
      // Low R_BITS of u are zero by construction; the quotient is below 2Q.
      s2_t      <= S_W'(u >> R_BITS);
      out_valid <= s2_valid;
      out_r     <= (s2_t >= Q_S) ? 12'(s2_t - Q_S) : s2_t[11:0];
    end
  end

endmodule

// File: tb/tb_mont_reduce.sv
// tb/tb_mont_reduce.sv - directed and random checks of the mont_reduce pipeline
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mont_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_t;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_r;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mont_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_t = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_r !== 12'd0) $display("FAIL reset_out_r got %0d want 0", out_r); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL idle_no_output got %0d valid cycles want 0", seen); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [23:0] vt [5];
    logic [11:0] ve [5];
    vt = '{24'd0, 24'd1, 24'd2285, 24'd3329, 24'd11075584};
    ve = '{12'd0, 12'd169, 12'd1, 12'd0, 12'd169};
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      in_valid = (c < 5);
      in_t     = (c < 5) ? vt[c] : 24'd0;
      #1;
      if (c >= 3 && c <= 7) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_r !== ve[c-3])
          $display("FAIL directed_%0d got valid=%b r=%0d want valid=1 r=%0d", c-3, out_valid, out_r, ve[c-3]);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL directed_idle_cyc%0d got valid=%b want 0", c, out_valid);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
  endtask

  // T = k*2285 reduces to k because 2285 = 2^16 mod q.
  task automatic test_backpressure();
    logic [11:0] held;
    int wi = 0;
    int ri = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (wi < 6);
      in_t      = 24'((wi + 2) * 2285);
      #1;
      if (c == 3) held = out_r;
      if (c >= 3 && c <= 6) begin
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
          $display("FAIL bp_stall_cyc%0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_r !== held) $display("FAIL bp_hold_cyc%0d got %0d want %0d", c, out_r, held);
        else pass_cnt++;
      end
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (out_r !== 12'(ri + 2)) $display("FAIL bp_word%0d got %0d want %0d", ri, out_r, ri + 2);
        else pass_cnt++;
        ri++;
      end
    end
    in_valid = 1'b0;
    total_cnt++; if (ri !== 6) $display("FAIL bp_count got %0d want 6", ri); else pass_cnt++;
  endtask

  task automatic test_bubbles();
    logic hist [16];
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      hist[c]  = (c < 10) && (c % 2 == 0);
      in_valid = hist[c];
      in_t     = 24'((c + 1) * 2285);
      #1;
      if (c >= 3) begin
        total_cnt++;
        if (out_valid !== hist[c-3] || (hist[c-3] && out_r !== 12'(c - 2)))
          $display("FAIL bubble_cyc%0d got valid=%b r=%0d want valid=%b r=%0d", c, out_valid, out_r, hist[c-3], c - 2);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_t     = 24'((c + 5) * 2285);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_r !== 12'd0)
      $display("FAIL midrst_after got valid=%b busy=%b r=%0d want 0/0/0", out_valid, busy, out_r);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL midrst_leak got %0d valid cycles want 0", seen); else pass_cnt++;
  endtask

  task automatic test_random();
    int          q_exp [$];
    int          sent = 0;
    int          recv = 0;
    int          cyc  = 0;
    int          a, b, exp_v;
    logic        need_new = 1'b1;
    localparam int N = 10000;
    while ((sent < N || recv < N) && cyc < 60000) begin
      @(negedge clk);
      if (need_new) begin
        a = $urandom_range(0, 3328);
        b = $urandom_range(0, 3328);
        need_new = 1'b0;
      end
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      in_t      = 24'(a * b);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q_exp.push_back(int'((longint'(a) * b * 169) % 3329));
        sent++;
        need_new = 1'b1;
      end
      if (out_valid && out_ready) begin
        exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        total_cnt++;
        if (int'(out_r) !== exp_v) $display("FAIL random_word%0d got %0d want %0d", recv, out_r, exp_v);
        else pass_cnt++;
        recv++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++; if (recv !== N) $display("FAIL random_count got %0d want %0d", recv, N); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    drain();
    test_backpressure();
    drain();
    test_bubbles();
    drain();
    test_reset_mid();
    drain();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
